fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL provide ports: clk_i  in  1  sole clock, rising edge.
REQ-003 SHALL provide rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL provide redirect_i  in  1  taken branch/JAL/JALR from execute stage.
REQ-005 SHALL provide target_i  in  32  redirect address, sampled when redirect_i=1.
REQ-006 SHALL provide imem_req_o  out  1, imem_addr_o  out  32, imem_gnt_i  in  1: request/grant handshake.
REQ-007 SHALL provide imem_rvalid_i  in  1, imem_rdata_i  in  32: response, at least 1 cycle after grant.
REQ-008 SHALL provide if_valid_o  out  1, id_ready_i  in  1, instr_o  out  32, instr_pc_o  out  32: decode handoff.
REQ-009 SHALL provide misalign_o  out  1: handed-off instruction carries misaligned-target fault.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, WAIT, FULL, plus 1-bit discard flag and 32-bit pc register.
REQ-011 IDLE: SHALL move to REQ in the next cycle; no request issued in IDLE.
REQ-012 REQ: SHALL drive imem_req_o=1, imem_addr_o=pc; on imem_gnt_i -> WAIT.
REQ-013 WAIT: SHALL drive imem_req_o=0; on imem_rvalid_i with discard=0, capture rdata/pc into output buffer, pc<=pc+4, -> FULL.
REQ-014 FULL: SHALL drive if_valid_o=1; on id_ready_i=1 (transfer) -> REQ next cycle; at most one request outstanding at any time.
REQ-015 Redirect SHALL take priority over every other event in the same cycle; pc<=target_i.
REQ-016 Redirect in REQ SHALL abort the ungranted request (including when imem_gnt_i=1 that same cycle: grant is then treated as outstanding, discard<=1, -> WAIT); otherwise stay REQ with imem_addr_o=target_i in the next cycle.
REQ-017 Redirect in WAIT without rvalid SHALL set discard<=1 and stay WAIT; the next rvalid SHALL be dropped, discard cleared, -> REQ.
REQ-018 Redirect in WAIT coincident with rvalid SHALL drop that data and go to REQ.
REQ-019 Redirect in FULL SHALL invalidate the buffer (if_valid_o=0 next cycle, even if id_ready_i=1 that cycle: no transfer counted) and -> REQ.
REQ-020 Any rvalid while discard=1 SHALL be dropped regardless of state.
REQ-021 Redirect-to-request latency SHALL be 1 cycle when no request is outstanding.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 instr_o, instr_pc_o, misalign_o SHALL be stable while if_valid_o=1 and id_ready_i=0.

Reset
REQ-024 rst_ni=0 SHALL asynchronously force: state=IDLE, pc=RESET_PC, discard=0, imem_req_o=0, if_valid_o=0, instr_o=0, instr_pc_o=0, misalign_o=0.
REQ-025 Reset asserted mid-transaction SHALL abandon the outstanding request; responses arriving while in IDLE SHALL be ignored.

Configuration
REQ-026 With FETCH_MISALIGN_CHK_EN defined: a redirect with target_i[1:0]!=0 SHALL not issue imem requests; block SHALL present if_valid_o=1, misalign_o=1, instr_o=32'h0000_0013, instr_pc_o=target, then halt in FULL until the next redirect.
REQ-027 Without FETCH_MISALIGN_CHK_EN: target_i[1:0] SHALL be forced to 2'b00 and misalign_o tied to 0.

Structure
REQ-028 SHALL place fetch FSM state enum, NOP encoding (32'h0000_0013) and default RESET_PC in a shared core package.
REQ-029 SHALL be a single module; no sub-module.

Verification
REQ-030 Reset release, gnt same cycle, rvalid +1, id_ready=1 -> addrs 0x0,0x4,0x8 issued in order; instr_pc_o matches.
REQ-031 Redirect to 0x100 in WAIT, stale rvalid 0xDEADBEEF -> data dropped; next req addr 0x100; if_valid_o never shows 0xDEADBEEF.
REQ-032 FULL with id_ready_i=0 for 5 cycles -> instr_o stable, imem_req_o=0 throughout.
REQ-033 Redirect to 0x200 with id_ready_i=1 in FULL -> no handoff; next req addr 0x200.
REQ-034 pc=0xFFFF_FFFC fetch completes -> next req addr 0x0000_0000.
REQ-035 FETCH_MISALIGN_CHK_EN, redirect to 0x102 -> no imem_req_o; if_valid_o=1, misalign_o=1, instr_pc_o=0x102.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-controller definitions: FSM state encoding, NOP encoding, default reset PC.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2,
    FS_FULL = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch FSM with redirect/discard handling and a one-entry decode buffer.
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirect targets present a faulting NOP instead of fetching.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        misalign_o
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_instr_pc;
  logic         r_discard;
  logic         r_valid;
  logic         r_misalign;
  logic [31:0]  w_target;
  logic         w_tgt_misaligned;
  logic         w_outstanding;

`ifdef FETCH_MISALIGN_CHK_EN
  assign w_target         = target_i;
  assign w_tgt_misaligned = (target_i[1:0] != 2'b00);
  assign misalign_o       = r_misalign;
`else
  assign w_target         = target_i & 32'hFFFF_FFFC;
  assign w_tgt_misaligned = 1'b0;
  assign misalign_o       = 1'b0;
`endif

  assign imem_req_o  = (r_state == FS_REQ);
  assign imem_addr_o = r_pc;
  assign if_valid_o  = r_valid;
  assign instr_o     = r_instr;
  assign instr_pc_o  = r_instr_pc;

  // A response is still owed to us after this cycle, so a redirect must discard it.
  always_comb begin
    w_outstanding = 1'b0;
    case (r_state)
      FS_REQ:  w_outstanding = imem_gnt_i;
      FS_WAIT: w_outstanding = !imem_rvalid_i;
      default: w_outstanding = r_discard && !imem_rvalid_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= FS_IDLE;
      r_pc       <= RESET_PC;
      r_discard  <= 1'b0;
      r_valid    <= 1'b0;
      r_instr    <= 32'h0000_0000;
      r_instr_pc <= 32'h0000_0000;
      r_misalign <= 1'b0;
    end else begin
      if (imem_rvalid_i && r_discard) begin
        r_discard <= 1'b0;
      end
      if (redirect_i) begin
        r_pc      <= w_target;
        r_discard <= w_outstanding;
        if (w_tgt_misaligned) begin
          // Halt on a faulting NOP; only another redirect leaves this.
          r_state    <= FS_FULL;
          r_valid    <= 1'b1;
          r_instr    <= NOP_INSTR;
          r_instr_pc <= w_target;
          r_misalign <= 1'b1;
        end else begin
          r_valid    <= 1'b0;
          r_misalign <= 1'b0;
          r_state    <= w_outstanding ? FS_WAIT : FS_REQ;
        end
      end else begin
        case (r_state)
          FS_IDLE: r_state <= FS_REQ;
          FS_REQ: begin
            if (imem_gnt_i) begin
              r_state <= FS_WAIT;
            end
          end
          FS_WAIT: begin
            if (imem_rvalid_i) begin
              if (r_discard) begin
                r_state <= FS_REQ;
              end else begin
                r_instr    <= imem_rdata_i;
                r_instr_pc <= r_pc;
                r_pc       <= pc_inc(r_pc);
                r_valid    <= 1'b1;
                r_misalign <= 1'b0;
                r_state    <= FS_FULL;
              end
            end
          end
          FS_FULL: begin
            if (id_ready_i && !r_misalign) begin
              r_valid <= 1'b0;
              r_state <= FS_REQ;
            end
          end
          default: begin
            r_valid <= 1'b0;
            r_state <= FS_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: transaction-level fetch model plus a randomized memory agent.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] STALE  = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] target_i = 32'h0;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        id_ready_i = 1'b0;
  logic        imem_req_o, if_valid_o, misalign_o;
  logic [31:0] imem_addr_o, instr_o, instr_pc_o;

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .redirect_i(redirect_i), .target_i(target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .if_valid_o(if_valid_o), .id_ready_i(id_ready_i), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_expect;              // pc of the next instruction decode should receive
  bit          pend = 0, pend_stale = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  bit          prev_hold = 0, exp_req_next = 0;
  logic [31:0] prev_instr, prev_pc;
  logic        prev_mis;
  int          idle_cnt = 0;
  int          p_gnt, p_ready, p_redir, lat_min, lat_max;
  logic [31:0] q_addr[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHK_EN
    return t;
`else
    return t & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic bit fetches_after(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHK_EN
    return (t[1:0] == 2'b00);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_FFFF);
`ifdef FETCH_MISALIGN_CHK_EN
    t = t & 32'hFFFF_FFFC;
`endif
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model; entered and left at a negedge.
  task automatic step(input bit f_redir, input logic [31:0] f_tgt);
    bit redir, gnt, rv, rdy;
    logic [31:0] tgt;
    if (imem_req_o) begin
      chk("one_outstanding", 32'(pend), 32'd0);
      chk("req_addr", imem_addr_o, m_expect);
      chk("req_while_valid", 32'(if_valid_o), 32'd0);
    end
    if (exp_req_next) chk("redirect_latency", 32'(imem_req_o), 32'd1);
    if (prev_hold) begin
      chk("hold_valid", 32'(if_valid_o), 32'd1);
      chk("hold_instr", instr_o, prev_instr);
      chk("hold_pc", instr_pc_o, prev_pc);
      chk("hold_misalign", 32'(misalign_o), 32'(prev_mis));
    end
    if (if_valid_o) begin
      n_checks++;
      assert (instr_o !== STALE) else begin
        n_fail++;
        $error("FAIL stale_visible: observed %h expected not %h", instr_o, STALE);
      end
    end
    idle_cnt = (imem_req_o || if_valid_o) ? 0 : idle_cnt + 1;
    n_checks++;
    assert (idle_cnt < 40) else begin
      n_fail++;
      $error("FAIL watchdog: observed %0d idle cycles expected < 40", idle_cnt);
    end

    redir = f_redir || ($urandom_range(99) < p_redir);
    tgt   = f_redir ? f_tgt : rand_target();
    rdy   = ($urandom_range(99) < p_ready);
    gnt   = imem_req_o && ($urandom_range(99) < p_gnt);
    if (redir && pend) pend_stale = 1;
    rv = 0;
    if (pend) begin
      if (pend_cnt == 0) rv = 1;
      else pend_cnt--;
    end
    redirect_i    = redir;
    target_i      = tgt;
    imem_gnt_i    = gnt;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? (pend_stale ? STALE : mem_word(pend_addr)) : $urandom;
    id_ready_i    = rdy;

    if (if_valid_o && rdy && !redir) begin
      chk("handoff_pc", instr_pc_o, m_expect);
      chk("handoff_instr", instr_o, mem_word(m_expect));
      chk("handoff_misalign", 32'(misalign_o), 32'd0);
      m_expect = m_expect + 32'd4;
    end
    prev_hold  = if_valid_o && !rdy && !redir;
    prev_instr = instr_o;
    prev_pc    = instr_pc_o;
    prev_mis   = misalign_o;
    if (rv) pend = 0;
    if (gnt) begin
      pend       = 1;
      pend_stale = redir;
      pend_addr  = imem_addr_o;
      pend_cnt   = int'($urandom_range(lat_max, lat_min)) - 1;
      q_addr.push_back(imem_addr_o);
    end
    if (redir) begin
      m_expect     = model_target(tgt);
      exp_req_next = !pend && fetches_after(tgt);
    end else begin
      exp_req_next = 0;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic run_until_valid();
    int b = 0;
    while (!if_valid_o && b < 40) begin step(0, 32'h0); b++; end
    chk("reach_valid", 32'(if_valid_o), 32'd1);
  endtask

  task automatic wait_req(output logic [31:0] addr);
    int b = 0;
    while (!imem_req_o && b < 40) begin step(0, 32'h0); b++; end
    chk("reach_req", 32'(imem_req_o), 32'd1);
    addr = imem_addr_o;
  endtask

  // Reset, then feed a stray response into the IDLE cycle that must be ignored.
  task automatic apply_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    redirect_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; id_ready_i = 1'b0;
    #1;
    chk("reset_req", 32'(imem_req_o), 32'd0);
    chk("reset_valid", 32'(if_valid_o), 32'd0);
    chk("reset_instr", instr_o, 32'd0);
    chk("reset_instr_pc", instr_pc_o, 32'd0);
    chk("reset_misalign", 32'(misalign_o), 32'd0);
    pend = 0; prev_hold = 0; exp_req_next = 0; idle_cnt = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    m_expect = RST_PC;
    chk("idle_no_req", 32'(imem_req_o), 32'd0);
    pend = 1; pend_cnt = 0; pend_stale = 1; pend_addr = 32'h0;
    step(0, 32'h0);
    chk("first_req", 32'(imem_req_o), 32'd1);
    chk("first_addr", imem_addr_o, RST_PC);
  endtask

  initial begin
    logic [31:0] got;
    p_gnt = 100; p_ready = 100; p_redir = 0; lat_min = 1; lat_max = 1;
    apply_reset();
    q_addr.delete();
    repeat (16) step(0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      got = (q_addr.size() > i) ? q_addr[i] : 32'hFFFF_FFFF;
      chk("seq_addr", got, RST_PC + 32'(i * 4));
    end

    // Redirect while a response is outstanding; its data must be dropped.
    lat_min = 3; lat_max = 3;
    begin
      int b = 0;
      while (!(pend && !imem_req_o) && b < 40) begin step(0, 32'h0); b++; end
      chk("reach_wait", 32'(pend && !imem_req_o), 32'd1);
    end
    step(1, 32'h0000_0100);
    wait_req(got);
    chk("redirect_wait_addr", got, 32'h0000_0100);
    lat_min = 1; lat_max = 2;

    // Decode stalls for five cycles.
    p_ready = 0;
    run_until_valid();
    repeat (5) begin
      chk("stall_no_req", 32'(imem_req_o), 32'd0);
      chk("stall_valid", 32'(if_valid_o), 32'd1);
      step(0, 32'h0);
    end

    // Redirect with decode ready in the same cycle: no handoff.
    p_ready = 100;
    step(1, 32'h0000_0200);
    chk("redirect_full_invalid", 32'(if_valid_o), 32'd0);
    wait_req(got);
    chk("redirect_full_addr", got, 32'h0000_0200);

    // pc wrap from the top of the address space.
    step(1, 32'hFFFF_FFFC);
    wait_req(got);
    chk("wrap_first_addr", got, 32'hFFFF_FFFC);
    step(0, 32'h0);
    wait_req(got);
    chk("wrap_next_addr", got, 32'h0000_0000);

`ifdef FETCH_MISALIGN_CHK_EN
    p_ready = 0;
    run_until_valid();
    step(1, 32'h0000_0102);
    repeat (4) begin
      chk("mis_no_req", 32'(imem_req_o), 32'd0);
      chk("mis_valid", 32'(if_valid_o), 32'd1);
      chk("mis_flag", 32'(misalign_o), 32'd1);
      chk("mis_instr", instr_o, 32'h0000_0013);
      chk("mis_pc", instr_pc_o, 32'h0000_0102);
      step(0, 32'h0);
    end
    p_ready = 100;
    step(1, 32'h0000_0300);
    wait_req(got);
    chk("mis_resume_addr", got, 32'h0000_0300);
`else
    step(1, 32'h0000_0102);
    wait_req(got);
    chk("mis_masked_addr", got, 32'h0000_0100);
`endif

    // Randomized traffic.
    p_gnt = 60; p_ready = 60; p_redir = 6; lat_min = 1; lat_max = 4;
    repeat (1500) step(0, 32'h0);

    // Reset while a request is outstanding.
    p_redir = 0;
    begin
      int b = 0;
      while (!pend && b < 40) begin step(0, 32'h0); b++; end
      chk("reach_pending", 32'(pend), 32'd1);
    end
    apply_reset();
    p_gnt = 100;
    repeat (12) step(0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
